// File: rtl/dsp_pkg.sv
// Shared DSP-chain types: FFT sideband and the power-integrator pipeline metadata.
// Pure declarations; no timing or flow-control behaviour of its own.
package dsp_pkg;

    localparam int FFT_NUM_POINTS    = 32;
    localparam int FFT_INDEX_WIDTH   = $clog2(FFT_NUM_POINTS);
    localparam int FFT_TAG_WIDTH     = 8;
    localparam int FFT_POWER_LATENCY = 5;

    typedef struct packed {
        logic                       valid;
        logic                       last;
        logic                       reverse;
        logic [FFT_INDEX_WIDTH-1:0] data_index;
        logic [FFT_TAG_WIDTH-1:0]   tag;
    } fft_control_t;

    typedef struct packed {
        fft_control_t ctrl;
        logic         is_first;
        logic         is_final;
    } power_meta_t;

    // A configured frame count of zero integrates a single frame.
    function automatic int unsigned frames_eff(input int unsigned cfg);
        return (cfg == 0) ? 1 : cfg;
    endfunction

endpackage

// File: rtl/fft_power_accum_ram.sv
// Per-bin accumulator store, simple dual port; registered read, 1 cycle.
// No backpressure: one write and one read may be issued every clock.
module fft_power_accum_ram #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 50,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: the first frame of every group overwrites each bin.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_power_accumulator.sv
// Per-bin I^2+Q^2 integrated over N FFT frames; 5-cycle input-to-output latency.
// No backpressure: the pipeline advances every clock and invalid samples flow as bubbles.
module fft_power_accumulator
    import dsp_pkg::*;
#(
    parameter int NUM_POINTS       = 32,
    parameter int INDEX_WIDTH      = $clog2(NUM_POINTS),
    parameter int INPUT_DATA_WIDTH = 21,
    parameter int POWER_WIDTH      = 2 * INPUT_DATA_WIDTH,
    parameter int NUM_FRAMES_WIDTH = 8,
    parameter int ACCUM_WIDTH      = POWER_WIDTH + NUM_FRAMES_WIDTH
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic [NUM_FRAMES_WIDTH-1:0]        Config_num_frames,
    input  fft_control_t                       Input_control,
    input  logic signed [INPUT_DATA_WIDTH-1:0] Input_i,
    input  logic signed [INPUT_DATA_WIDTH-1:0] Input_q,
    output fft_control_t                       Output_control,
    output logic [ACCUM_WIDTH-1:0]             Output_power,
    output logic                               Error_sequence
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_POINTS - 1);

    logic [INDEX_WIDTH-1:0]      exp_idx;
    logic                        resync;
    logic [NUM_FRAMES_WIDTH-1:0] frame_cnt, n_eff, n_eff_now;
    logic                        in_vld, seq_err, accept, group_start;
    power_meta_t                 in_meta;

    power_meta_t                        s0_meta, s1_meta, s2_meta, s3_meta;
    logic signed [INPUT_DATA_WIDTH-1:0] s0_i, s0_q;
    logic                               s0_err;
    logic signed [POWER_WIDTH-1:0]      i_ext, q_ext;
    logic [POWER_WIDTH-1:0]             s1_ii, s1_qq, s2_pwr, s3_pwr;
    logic [ACCUM_WIDTH-1:0]             rd_data, acc;

    always_comb begin
        in_vld      = Input_control.valid;
        seq_err     = in_vld && !resync &&
                      ((Input_control.data_index != exp_idx) ||
                       (Input_control.last != (Input_control.data_index == LAST_IDX)));
        accept      = in_vld && !resync && !seq_err;
        group_start = (frame_cnt == '0) && (exp_idx == '0);
        // The group length is sampled at bin 0 of the group's first frame only.
        n_eff_now   = group_start ? NUM_FRAMES_WIDTH'(frames_eff(32'(Config_num_frames))) : n_eff;
        in_meta          = '0;
        in_meta.ctrl     = Input_control;
        in_meta.ctrl.valid = accept;
        in_meta.is_first = (frame_cnt == '0);
        in_meta.is_final = (frame_cnt == n_eff_now - NUM_FRAMES_WIDTH'(1));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exp_idx   <= '0;
            resync    <= 1'b0;
            frame_cnt <= '0;
            n_eff     <= '0;
        end else if (accept) begin
            exp_idx <= Input_control.last ? '0 : exp_idx + INDEX_WIDTH'(1);
            if (group_start) begin
                n_eff <= n_eff_now;
            end
            if (Input_control.last) begin
                frame_cnt <= in_meta.is_final ? '0 : frame_cnt + NUM_FRAMES_WIDTH'(1);
            end
        end else if (seq_err) begin
            // Abort the group; if the bad sample was not a frame end, skip to the next one.
            exp_idx   <= '0;
            frame_cnt <= '0;
            resync    <= !Input_control.last;
        end else if (in_vld && resync && Input_control.last) begin
            resync <= 1'b0;
        end
    end

    always_comb begin
        i_ext = POWER_WIDTH'(s0_i);
        q_ext = POWER_WIDTH'(s0_q);
        acc   = s3_meta.is_first ? ACCUM_WIDTH'(s3_pwr) : rd_data + ACCUM_WIDTH'(s3_pwr);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s0_meta        <= '0;
            s0_i           <= '0;
            s0_q           <= '0;
            s0_err         <= 1'b0;
            s1_meta        <= '0;
            s1_ii          <= '0;
            s1_qq          <= '0;
            Error_sequence <= 1'b0;
            s2_meta        <= '0;
            s2_pwr         <= '0;
            s3_meta        <= '0;
            s3_pwr         <= '0;
            Output_control <= '0;
            Output_power   <= '0;
        end else begin
            s0_meta        <= in_meta;
            s0_i           <= Input_i;
            s0_q           <= Input_q;
            s0_err         <= seq_err;
            s1_meta        <= s0_meta;
            s1_ii          <= i_ext * i_ext;
            s1_qq          <= q_ext * q_ext;
            Error_sequence <= s0_err;
            s2_meta        <= s1_meta;
            s2_pwr         <= s1_ii + s1_qq;
            s3_meta        <= s2_meta;
            s3_pwr         <= s2_pwr;
            if (s3_meta.ctrl.valid && s3_meta.is_final) begin
                Output_control <= s3_meta.ctrl;
                Output_power   <= acc;
            end else begin
                Output_control <= '0;
                Output_power   <= '0;
            end
        end
    end

    // A bin is revisited at most once per frame, so S3 read and S4 write never collide.
    fft_power_accum_ram #(
        .DEPTH (NUM_POINTS),
        .WIDTH (ACCUM_WIDTH)
    ) u_ram (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .wr_en   (s3_meta.ctrl.valid),
        .wr_addr (s3_meta.ctrl.data_index),
        .wr_data (acc),
        .rd_en   (s2_meta.ctrl.valid),
        .rd_addr (s2_meta.ctrl.data_index),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fft_power_accumulator.sv
// Directed bench for fft_power_accumulator: vector table of uniform groups plus corner sequences.
module tb_fft_power_accumulator;
    import dsp_pkg::*;

    localparam int W  = 21;
    localparam int AW = 50;

    logic                Clk = 1'b0;
    logic                Rst_n;
    logic [7:0]          cfg;
    fft_control_t        in_ctrl, out_ctrl;
    logic signed [W-1:0] in_i, in_q;
    logic [AW-1:0]       out_pow;
    logic                err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int err_seen = 0;
    int err_before;

    typedef struct {
        logic [4:0]    idx;
        logic          last;
        logic          rev;
        logic [7:0]    tag;
        logic [AW-1:0] power;
        int            cyc;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        logic [7:0]          cfg;
        int                  nfr;
        logic signed [W-1:0] i;
        logic signed [W-1:0] q;
        logic                rev;
        int                  tag0;
        int                  neff;
        logic [AW-1:0]       grp_pow;
    } vec_t;
    vec_t vecs[5];

    fft_power_accumulator dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .Config_num_frames (cfg),
        .Input_control     (in_ctrl),
        .Input_i           (in_i),
        .Input_q           (in_q),
        .Output_control    (out_ctrl),
        .Output_power      (out_pow),
        .Error_sequence    (err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (err) err_seen++;
            if (out_ctrl.valid) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output idx=%0d tag=%0h power=%0d cyc=%0d",
                             out_ctrl.data_index, out_ctrl.tag, out_pow, cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (out_ctrl.data_index !== e.idx || out_ctrl.last !== e.last ||
                        out_ctrl.reverse !== e.rev || out_ctrl.tag !== e.tag ||
                        out_pow !== e.power || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL out_sample got idx=%0d last=%0d rev=%0d tag=%0h power=%0d cyc=%0d want idx=%0d last=%0d rev=%0d tag=%0h power=%0d cyc=%0d",
                                 out_ctrl.data_index, out_ctrl.last, out_ctrl.reverse, out_ctrl.tag, out_pow, cyc,
                                 e.idx, e.last, e.rev, e.tag, e.power, e.cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input int idx, input logic signed [W-1:0] i, input logic signed [W-1:0] q,
                         input logic rev, input int tag, input logic expect_out, input logic [AW-1:0] pwr);
        exp_t e;
        @(posedge Clk);
        #1;
        in_ctrl.valid      = 1'b1;
        in_ctrl.last       = (idx == 31);
        in_ctrl.reverse    = rev;
        in_ctrl.data_index = 5'(idx);
        in_ctrl.tag        = 8'(tag);
        in_i = i;
        in_q = q;
        if (expect_out) begin
            e.idx   = 5'(idx);
            e.last  = (idx == 31);
            e.rev   = rev;
            e.tag   = 8'(tag);
            e.power = pwr;
            e.cyc   = cyc + FFT_POWER_LATENCY;
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            in_ctrl = '0;
        end
    endtask

    task automatic send_frame(input logic signed [W-1:0] i, input logic signed [W-1:0] q, input logic rev,
                              input int tag, input logic expect_out, input logic [AW-1:0] pwr,
                              input int skip, input int gap_max);
        for (int k = 0; k < 32; k++) begin
            if (k != skip) begin
                drive(k, i, q, rev, tag, expect_out, pwr);
                if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
            end
        end
        idle(1);
    endtask

    task automatic check_drained(input string name);
        repeat (FFT_POWER_LATENCY + 3) @(posedge Clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL %s missing_outputs got=%0d want=0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (out_ctrl !== '0 || out_pow !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL %s reset_state ctrl=%0h power=%0d err=%0b want all 0", name, out_ctrl, out_pow, err);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cfg: 8'd4,   nfr: 4,   i: -21'sd100,   q: 21'sd0,      rev: 1'b1, tag0: 1,    neff: 4,   grp_pow: 50'd40000};
        vecs[1] = '{cfg: 8'd255, nfr: 255, i: 21'sh100000, q: 21'sh100000, rev: 1'b0, tag0: 0,    neff: 255, grp_pow: 50'd560750930165760};
        vecs[2] = '{cfg: 8'd0,   nfr: 2,   i: 21'sd7,      q: -21'sd24,    rev: 1'b1, tag0: 'h10, neff: 1,   grp_pow: 50'd625};
        vecs[3] = '{cfg: 8'd2,   nfr: 4,   i: 21'sd1000,   q: -21'sd1000,  rev: 1'b0, tag0: 'h20, neff: 2,   grp_pow: 50'd4000000};
        vecs[4] = '{cfg: 8'd3,   nfr: 3,   i: -21'sd1,     q: 21'sd1,      rev: 1'b1, tag0: 'h30, neff: 3,   grp_pow: 50'd6};

        Rst_n   = 1'b0;
        cfg     = 8'd1;
        in_ctrl = '0;
        in_i    = '0;
        in_q    = '0;
        #3;
        check_idle_outputs("reset0");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        idle(2);

        // Single-frame group, one non-zero bin.
        cfg = 8'd1;
        for (int k = 0; k < 32; k++)
            drive(k, (k == 5) ? 21'sd3 : 21'sd0, (k == 5) ? 21'sd4 : 21'sd0, 1'b0, 'h2A, 1'b1,
                  (k == 5) ? 50'd25 : 50'd0);
        idle(1);
        check_drained("neff1");

        for (int v = 0; v < 5; v++) begin
            cfg = vecs[v].cfg;
            for (int f = 0; f < vecs[v].nfr; f++)
                send_frame(vecs[v].i, vecs[v].q, vecs[v].rev, vecs[v].tag0 + f,
                           ((f + 1) % vecs[v].neff) == 0, vecs[v].grp_pow, -1, 0);
            check_drained($sformatf("vec%0d", v));
        end

        // Index 7 missing in frame 2 of a 3-frame group.
        cfg = 8'd3;
        err_before = err_seen;
        send_frame(21'sd50, 21'sd0, 1'b0, 'h40, 1'b0, '0, -1, 0);
        send_frame(21'sd50, 21'sd0, 1'b0, 'h40, 1'b0, '0, 7, 0);
        send_frame(21'sd10, 21'sd0, 1'b0, 'h41, 1'b0, '0, -1, 0);
        send_frame(21'sd10, 21'sd0, 1'b0, 'h42, 1'b0, '0, -1, 0);
        send_frame(21'sd10, 21'sd0, 1'b0, 'h43, 1'b1, 50'd300, -1, 0);
        check_drained("seq_err");
        checks++;
        if (err_seen - err_before != 1) begin
            failures++;
            $display("FAIL seq_err_pulses got=%0d want=1", err_seen - err_before);
        end

        // Config raised mid-group: the current group keeps 2, the next one uses 3.
        cfg = 8'd2;
        fork
            send_frame(21'sd3, 21'sd0, 1'b1, 'h50, 1'b0, '0, -1, 0);
            begin
                repeat (12) @(posedge Clk);
                #2;
                cfg = 8'd3;
            end
        join
        send_frame(21'sd3, 21'sd0, 1'b1, 'h51, 1'b1, 50'd18, -1, 0);
        send_frame(21'sd3, 21'sd0, 1'b1, 'h52, 1'b0, '0, -1, 0);
        send_frame(21'sd3, 21'sd0, 1'b1, 'h53, 1'b0, '0, -1, 0);
        send_frame(21'sd3, 21'sd0, 1'b1, 'h54, 1'b1, 50'd27, -1, 0);
        check_drained("cfg_change");

        // Reset in the middle of frame 2 of 4, then a gapped clean group.
        cfg = 8'd4;
        send_frame(21'sd200, 21'sd0, 1'b0, 'h60, 1'b0, '0, -1, 0);
        for (int k = 0; k < 16; k++) drive(k, 21'sd200, 21'sd0, 1'b0, 'h61, 1'b0, '0);
        @(posedge Clk);
        #1;
        Rst_n   = 1'b0;
        in_ctrl = '0;
        #2;
        check_idle_outputs("reset_mid");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        idle(1);
        for (int f = 0; f < 4; f++)
            send_frame(21'sd5, 21'sd5, 1'b1, 'h70 + f, f == 3, 50'd200, -1, 5);
        check_drained("reset_gap");

        checks++;
        if (err_seen != 1) begin
            failures++;
            $display("FAIL total_err_pulses got=%0d want=1", err_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
